spi_mem_loader: RTL and testbench

SPI slave that loads and inspects the shared program/data RAM through its second port (the SPI loader/debugger port) while the CPU owns the first port. An external host streams byte-addressed 32-bit words in or out over mode-0 SPI; all SPI pins are synchronised into the system clock, so the SPI clock is never used as a clock. The block also drives a CPU hold line so the host can freeze the core during loading.

---
 rtl/spi_mem_loader.sv | 185 ++++++++++++++++++
 tb/tb_spi_mem_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_loader.sv
// spi_mem_loader: mode-0 SPI slave that loads and inspects RAM port B.
// SPI pins are oversampled in the clk domain; sclk is never a clock.
module spi_mem_loader #(
  parameter int SYNC_STAGES = 2,
  parameter bit HOLD_RESET  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        we_b,
  output logic [31:0] addr_b,
  output logic [31:0] wd_b,
  input  logic [31:0] rd_b,
  output logic        cpu_hold,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR_WR,
    ADDR_RD,
    WDATA,
    DUMMY,
    RDATA,
    IGNORE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_ff, cs_ff, mosi_ff;
  logic        sclk_q, cs_q;
  logic        sclk_s, cs_s, mosi_s;
  logic        rise, fall, cs_fall, cs_rise;
  logic [4:0]  bit_cnt;
  logic        len8, last_bit;
  logic [30:0] sh_in;
  logic [7:0]  byte_in;
  logic [31:0] word_in;
  logic [31:0] addr_q, addr_nx;
  logic [31:0] sh_out, pf;
  logic [1:0]  cap_q;
  logic        load_pend;

  assign sclk_s  = sclk_ff[SYNC_STAGES-1];
  assign cs_s    = cs_ff[SYNC_STAGES-1];
  assign mosi_s  = mosi_ff[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_q;
  assign fall    = ~sclk_s & sclk_q;
  assign cs_fall = ~cs_s & cs_q;
  assign cs_rise = cs_s & ~cs_q;

  assign busy        = ~cs_s;
  assign spi_miso_oe = ~cs_s;
  assign spi_miso    = (state_q == RDATA) & sh_out[31];

  assign len8     = (state_q == CMD) || (state_q == DUMMY);
  assign last_bit = rise && (len8 ? (bit_cnt == 5'd7) : (bit_cnt == 5'd31));
  assign byte_in  = {sh_in[6:0], mosi_s};
  assign word_in  = {sh_in, mosi_s};
  assign addr_nx  = addr_q + 32'd4;

  // Synchronise SPI pins and keep previous levels for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_ff <= '0;
      cs_ff   <= '1;
      mosi_ff <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
    end else begin
      sclk_ff <= {sclk_ff[SYNC_STAGES-2:0], spi_sclk};
      cs_ff   <= {cs_ff[SYNC_STAGES-2:0], spi_cs_n};
      mosi_ff <= {mosi_ff[SYNC_STAGES-2:0], spi_mosi};
      sclk_q  <= sclk_s;
      cs_q    <= cs_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode; a cs rise always returns to IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cs_fall) state_d = CMD;
      CMD: begin
        if (last_bit) begin
          case (byte_in)
            8'h02:   state_d = ADDR_WR;
            8'h03:   state_d = ADDR_RD;
            default: state_d = IGNORE;
          endcase
        end
      end
      ADDR_WR: if (last_bit) state_d = WDATA;
      ADDR_RD: if (last_bit) state_d = DUMMY;
      DUMMY:   if (last_bit) state_d = RDATA;
      WDATA, RDATA, IGNORE: ;
    endcase
    if (cs_rise) state_d = IDLE;
  end

  // Bit counter and MOSI shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      sh_in   <= '0;
    end else begin
      if (rise) sh_in <= word_in[30:0];
      if (cs_fall || cs_rise || last_bit) bit_cnt <= '0;
      else if (rise)                      bit_cnt <= bit_cnt + 5'd1;
    end
  end

  // RAM port, address, read pipeline, MISO shifter and CPU hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_b      <= 1'b0;
      addr_b    <= '0;
      wd_b      <= '0;
      addr_q    <= '0;
      cap_q     <= '0;
      pf        <= '0;
      sh_out    <= '0;
      load_pend <= 1'b0;
      cpu_hold  <= HOLD_RESET;
    end else begin
      we_b  <= 1'b0;
      cap_q <= {cap_q[0], 1'b0};
      if (cap_q[1]) pf <= rd_b;
      if (cs_fall) begin
        sh_out    <= '0;
        load_pend <= 1'b0;
      end
      unique case (1'b1)
        last_bit && state_q == CMD: begin
          if (byte_in == 8'hA0)      cpu_hold <= 1'b1;
          else if (byte_in == 8'hA1) cpu_hold <= 1'b0;
        end
        last_bit && state_q == ADDR_WR: begin
          addr_q <= {word_in[31:2], 2'b00};
        end
        last_bit && state_q == ADDR_RD: begin
          addr_q <= {word_in[31:2], 2'b00};
          addr_b <= {word_in[31:2], 2'b00};
          cap_q  <= {cap_q[0], 1'b1};
        end
        last_bit && state_q == WDATA: begin
          we_b   <= 1'b1;
          wd_b   <= word_in;
          addr_b <= addr_q;
          addr_q <= addr_nx;
        end
        last_bit && state_q == DUMMY: begin
          load_pend <= 1'b1;
        end
        last_bit && state_q == RDATA: begin
          addr_q    <= addr_nx;
          addr_b    <= addr_nx;
          cap_q     <= {cap_q[0], 1'b1};
          load_pend <= 1'b1;
        end
        fall && state_q == RDATA: begin
          if (load_pend) begin
            sh_out    <= pf;
            load_pend <= 1'b0;
          end else begin
            sh_out <= {sh_out[30:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_loader.sv
// tb_spi_mem_loader: directed SPI host with write scoreboard and RAM model.
// Host drives mode-0 SPI at clk/12 and samples MISO on sclk rise.
module tb_spi_mem_loader;

  localparam int HALF = 60;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_sclk, spi_cs_n, spi_mosi;
  logic        spi_miso, spi_miso_oe;
  logic        we_b;
  logic [31:0] addr_b, wd_b, rd_b;
  logic        cpu_hold, busy;

  int checks   = 0;
  int failures = 0;
  int we_count = 0;
  logic we_prev = 1'b0;

  logic [63:0] wq[$];
  logic [31:0] mem [256];

  spi_mem_loader #(.SYNC_STAGES(2), .HOLD_RESET(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .we_b        (we_b),
    .addr_b      (addr_b),
    .wd_b        (wd_b),
    .rd_b        (rd_b),
    .cpu_hold    (cpu_hold),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, one-clk read latency
  always @(posedge clk) begin
    if (we_b) mem[addr_b[9:2]] <= wd_b;
    rd_b <= mem[addr_b[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write monitor: every we_b pulse is popped from the scoreboard
  always @(negedge clk) begin
    if (rst_n && we_b) begin
      we_count++;
      chk("we_width", 32'(we_prev), 32'd0);
      chk("we_expected", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        logic [63:0] e;
        e = wq.pop_front();
        chk("we_addr", addr_b, e[63:32]);
        chk("we_data", wd_b, e[31:0]);
      end
    end
    we_prev = we_b;
  end

  task automatic spi_bits(input logic [31:0] v, input int n,
                          output logic [31:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = v[i];
      #(HALF);
      spi_sclk = 1'b1;
      rx = {rx[30:0], spi_miso};
      #(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_lo();
    spi_cs_n = 1'b0;
    #(HALF);
  endtask

  task automatic cs_hi();
    #(HALF);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    #(HALF * 4);
  endtask

  task automatic cmd_only(input logic [7:0] c);
    logic [31:0] rx;
    cs_lo();
    spi_bits({24'd0, c}, 8, rx);
    cs_hi();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rx;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst_n    = 1'b0;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_we", 32'(we_b), 32'd0);
    chk("rst_oe", 32'(spi_miso_oe), 32'd0);
    chk("rst_addr", addr_b, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    #1;

    wq.push_back({32'h0000_0010, 32'hDEAD_BEEF});
    wq.push_back({32'h0000_0014, 32'h1234_5678});
    cs_lo();
    chk("busy_active", 32'(busy), 32'd1);
    chk("oe_active", 32'(spi_miso_oe), 32'd1);
    spi_bits(32'h02, 8, rx);
    spi_bits(32'h0000_0010, 32, rx);
    spi_bits(32'hDEAD_BEEF, 32, rx);
    spi_bits(32'h1234_5678, 32, rx);
    cs_hi();
    chk("wr_count", 32'(we_count), 32'd2);

    cs_lo();
    spi_bits(32'h03, 8, rx);
    spi_bits(32'h0000_0010, 32, rx);
    spi_bits(32'h0, 8, rx);
    spi_bits(32'h0, 32, rx);
    chk("rd_word0", rx, 32'hDEAD_BEEF);
    spi_bits(32'h0, 32, rx);
    chk("rd_word1", rx, 32'h1234_5678);
    cs_hi();
    chk("rd_no_we", 32'(we_count), 32'd2);
    chk("rd_addr_hold", addr_b, 32'h0000_0018);
    chk("idle_miso", 32'(spi_miso), 32'd0);
    chk("idle_oe", 32'(spi_miso_oe), 32'd0);

    wq.push_back({32'hFFFF_FFFC, 32'hCAFE_F00D});
    wq.push_back({32'h0000_0000, 32'h0BAD_C0DE});
    cs_lo();
    spi_bits(32'h02, 8, rx);
    spi_bits(32'hFFFF_FFFC, 32, rx);
    spi_bits(32'hCAFE_F00D, 32, rx);
    spi_bits(32'h0BAD_C0DE, 32, rx);
    cs_hi();
    chk("wrap_count", 32'(we_count), 32'd4);

    cs_lo();
    spi_bits(32'h02, 8, rx);
    spi_bits(32'h0000_0040, 32, rx);
    spi_bits(32'h000A_BCDE, 20, rx);
    cs_hi();
    chk("abort_no_we", 32'(we_count), 32'd4);

    cmd_only(8'hA1);
    chk("hold_clear", 32'(cpu_hold), 32'd0);
    cmd_only(8'hA0);
    chk("hold_set", 32'(cpu_hold), 32'd1);

    cs_lo();
    spi_bits(32'h55, 8, rx);
    spi_bits(32'hFFFF_FFFF, 32, rx);
    chk("ign_miso_a", rx, 32'd0);
    spi_bits(32'hFF, 8, rx);
    chk("ign_miso_b", rx, 32'd0);
    cs_hi();
    chk("ign_no_we", 32'(we_count), 32'd4);
    chk("ign_hold", 32'(cpu_hold), 32'd1);

    cmd_only(8'hA1);
    chk("hold_clear2", 32'(cpu_hold), 32'd0);
    cs_lo();
    spi_bits(32'h02, 8, rx);
    spi_bits(32'h0000_0080, 32, rx);
    spi_bits(32'h0000_F00F, 16, rx);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(we_b), 32'd0);
    chk("mid_rst_addr", addr_b, 32'd0);
    chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("mid_rst_no_we", 32'(we_count), 32'd4);
    chk("sb_empty", 32'(wq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
